// File: rtl/reg_file_mp_if.sv
// Register-file access bundle: one write port, NRD packed read ports and status flags.
interface reg_file_mp_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                busy;
  logic                wr_drop;

  modport master (
    output wr_en, wr_addr, wr_data, rs_addr,
    input  rd_data, busy, wr_drop
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rs_addr,
    output rd_data, busy, wr_drop
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardwired x0 and a sequenced post-reset clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_mp #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2
) (
  input logic          clk,
  input logic          reset,
  reg_file_mp_if.slave bus
);
  localparam int unsigned AW      = $clog2(NREGS);
  localparam logic [AW:0] LastIdx = (AW+1)'(NREGS - 1);

  typedef enum logic {StClear, StReady} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     clr_idx_q, clr_idx_d;
  logic            wr_drop_q, wr_drop_d;
  logic            busy;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem [NREGS];

  assign busy = (state_q == StClear);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // The clear sequence owns the single array write port until it finishes.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q[AW-1:0];
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + (AW+1)'(1);
        wr_drop_d = bus.wr_en;
        if (clr_idx_q == LastIdx) state_d = StReady;
      end
      StReady: begin
        mem_we = bus.wr_en && (bus.wr_addr != '0);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   raddr;
    logic [XLEN-1:0] rword;

    assign raddr = bus.rs_addr[i*AW +: AW];

    always_comb begin
      rword = mem[raddr];
`ifdef REGFILE_BYPASS_EN
      if (bus.wr_en && (bus.wr_addr != '0) && (raddr == bus.wr_addr)) rword = bus.wr_data;
`endif
      // Zeroing rules win over both the array and forwarding.
      if (busy || (raddr == '0)) rword = '0;
    end

    assign bus.rd_data[i*XLEN +: XLEN] = rword;
  end

  assign bus.busy    = busy;
  assign bus.wr_drop = wr_drop_q;

endmodule
